pd_lane_scheduler: RTL and testbench

- Time-shares one pattern_detector instance between N vehicle-symbol lanes (BIKE=0, CAR=1), granting one lane at a time in round-robin frames.
- Clears the detector and programs its Moore mode (overlapping or non-overlapping) per lane before each frame, then forwards the lane's symbols.
- Attributes detector hits to the granted lane and keeps a saturating hit counter per lane.
- Sits between the lane sensors and the detector.

---
 rtl/pd_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/pd_lane_scheduler.sv | 168 ++++++++++++++++
 tb/tb_pd_lane_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types for the pattern-detector lane scheduler: symbols, FSM states,
// and the two-bit detector mode encoding {moore_ol, moore_nol}.
package pd_pkg;

  localparam logic SYM_BIKE = 1'b0;
  localparam logic SYM_CAR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pd_state_e;

  typedef enum logic [1:0] {
    MODE_NOL = 2'b01,
    MODE_OL  = 2'b10
  } pd_mode_e;

  function automatic pd_mode_e mode_sel(input logic ol);
    return ol ? MODE_OL : MODE_NOL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: the first requester after ptr (mod N) wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);

  int idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = PW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pd_lane_scheduler.sv
// Time-shares one pattern detector between N symbol lanes in round-robin frames,
// programming the detector mode per lane and crediting hits to the granted lane.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid lanes
// CLEAR | one cycle: clear detector, latch lane mode
// RUN   | forward granted lane's symbols until frame length or idle timeout
// DRAIN | PD_LAT+1 cycles so late detector hits still credit the lane
module pd_lane_scheduler
  import pd_pkg::*;
#(
  parameter int N         = 4,
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 8,
  parameter int PD_LAT    = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N-1:0]         req_data_i,
  output logic [N-1:0]         req_ready_o,
  input  logic [N-1:0]         lane_ol_i,
  input  logic                 cnt_clr_i,
  output logic                 pd_clear_o,
  output logic                 pd_valid_o,
  output logic                 pd_data_o,
  output logic                 pd_moore_ol_o,
  output logic                 pd_moore_nol_o,
  input  logic                 pd_detected_i,
  output logic [N-1:0]         grant_o,
  output logic [N-1:0]         det_pulse_o,
  output logic [N*CNT_W-1:0]   det_count_o,
  output logic                 busy_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(PD_LAT + 2);

  pd_state_e      state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [FW-1:0]  frame_tmr;
  logic [TW-1:0]  idle_tmr;
  logic [DW-1:0]  drain_tmr;

  logic [N-1:0]   arb_gnt;
  logic [PW-1:0]  arb_idx;
  logic           arb_valid;

  logic           accept;
  logic           det_prev;
  logic           hit;
  logic [CNT_W-1:0] cnt [N];

  rr_arbiter #(.N(N)) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // ready is only ever non-zero in RUN, so this is the RUN-state accept
  assign accept = |(req_valid_i & req_ready_o);
  assign hit    = pd_detected_i & ~det_prev & ((state == RUN) | (state == DRAIN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      ptr            <= PW'(N - 1);
      gidx           <= '0;
      grant_o        <= '0;
      req_ready_o    <= '0;
      pd_clear_o     <= 1'b0;
      pd_valid_o     <= 1'b0;
      pd_data_o      <= SYM_BIKE;
      pd_moore_ol_o  <= 1'b0;
      pd_moore_nol_o <= 1'b0;
      frame_tmr      <= '0;
      idle_tmr       <= '0;
      drain_tmr      <= '0;
      busy_o         <= 1'b0;
    end else begin
      pd_clear_o <= 1'b0;
      pd_valid_o <= accept;
      if (accept) pd_data_o <= req_data_i[gidx];

      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_o    <= arb_gnt;
            gidx       <= arb_idx;
            pd_clear_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= CLEAR;
          end
        end

        CLEAR: begin
          {pd_moore_ol_o, pd_moore_nol_o} <= mode_sel(lane_ol_i[gidx]);
          req_ready_o <= grant_o;
          frame_tmr   <= FW'(FRAME_LEN - 1);
          idle_tmr    <= TW'(TIMEOUT - 1);
          state       <= RUN;
        end

        RUN: begin
          if (accept) begin
            idle_tmr <= TW'(TIMEOUT - 1);
            if (frame_tmr == '0) begin
              req_ready_o <= '0;
              drain_tmr   <= DW'(PD_LAT);
              state       <= DRAIN;
            end else begin
              frame_tmr <= frame_tmr - 1'b1;
            end
          end else if (idle_tmr == '0) begin
            req_ready_o <= '0;
            drain_tmr   <= DW'(PD_LAT);
            state       <= DRAIN;
          end else begin
            idle_tmr <= idle_tmr - 1'b1;
          end
        end

        DRAIN: begin
          if (drain_tmr == '0) begin
            ptr     <= gidx;
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else begin
            drain_tmr <= drain_tmr - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // a counter clear beats a same-cycle hit; the pulse still fires
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      det_prev    <= 1'b0;
      det_pulse_o <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      det_prev    <= pd_detected_i;
      det_pulse_o <= hit ? grant_o : '0;
      for (int i = 0; i < N; i++) begin
        if (cnt_clr_i)
          cnt[i] <= '0;
        else if (hit && grant_o[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    det_count_o = '0;
    for (int i = 0; i < N; i++) det_count_o[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_pd_lane_scheduler.sv
// Directed bench for pd_lane_scheduler with a frame-level reference model
// checked every cycle, plus hand-computed scenario expectations.
module tb_pd_lane_scheduler;

  localparam int N = 2, FRAME_LEN = 8, TIMEOUT = 4, PD_LAT = 2, CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid_i = '0;
  logic [N-1:0]     req_data_i = '0;
  logic [N-1:0]     req_ready_o;
  logic [N-1:0]     lane_ol_i = 2'b01;
  logic             cnt_clr_i = 1'b0;
  logic             pd_clear_o, pd_valid_o, pd_data_o;
  logic             pd_moore_ol_o, pd_moore_nol_o;
  logic             pd_detected_i = 1'b0;
  logic [N-1:0]     grant_o, det_pulse_o;
  logic [N*CNT_W-1:0] det_count_o;
  logic             busy_o;

  int n_checks = 0;
  int n_err = 0;

  pd_lane_scheduler #(
    .N(N), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT), .PD_LAT(PD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .lane_ol_i(lane_ol_i), .cnt_clr_i(cnt_clr_i),
    .pd_clear_o(pd_clear_o), .pd_valid_o(pd_valid_o), .pd_data_o(pd_data_o),
    .pd_moore_ol_o(pd_moore_ol_o), .pd_moore_nol_o(pd_moore_nol_o),
    .pd_detected_i(pd_detected_i),
    .grant_o(grant_o), .det_pulse_o(det_pulse_o), .det_count_o(det_count_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int lane);
    logic [N-1:0] r;
    r = '0;
    if (lane >= 0) r[lane] = 1'b1;
    return r;
  endfunction

  // Reference model: lane = granted lane (-1 none), rdy = lane open for symbols
  int m_lane, m_rdy, m_ptr, m_acc, m_idle, m_drain, m_pulse, m_nl;
  bit m_inclear, m_clear, m_valid, m_data, m_ol, m_nol, m_busy, m_prev, m_hit, m_a;
  int m_cnt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lane = -1; m_rdy = -1; m_ptr = N - 1; m_acc = 0; m_idle = 0; m_drain = 0;
      m_pulse = -1; m_inclear = 0; m_clear = 0; m_valid = 0; m_data = 0;
      m_ol = 0; m_nol = 0; m_busy = 0; m_prev = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_hit = pd_detected_i && !m_prev && (m_lane >= 0) && !m_inclear;
      m_prev = pd_detected_i;
      m_pulse = m_hit ? m_lane : -1;
      if (cnt_clr_i) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (m_hit && m_cnt[m_lane] < (1 << CNT_W) - 1) begin
        m_cnt[m_lane]++;
      end
      m_a = (m_rdy >= 0) && req_valid_i[m_rdy];
      m_valid = m_a;
      if (m_a) m_data = req_data_i[m_rdy];
      m_clear = 0;
      if (m_lane < 0) begin
        if (req_valid_i != '0) begin
          m_nl = 0;
          for (int k = 1; k <= N; k++) begin
            m_nl = (m_ptr + k) % N;
            if (req_valid_i[m_nl]) break;
          end
          m_lane = m_nl; m_clear = 1; m_inclear = 1; m_busy = 1;
        end
      end else if (m_inclear) begin
        m_ol = lane_ol_i[m_lane]; m_nol = !m_ol;
        m_inclear = 0; m_rdy = m_lane; m_acc = 0; m_idle = 0;
      end else if (m_rdy >= 0) begin
        if (m_a) begin m_acc++; m_idle = 0; end
        else m_idle++;
        if (m_acc == FRAME_LEN || m_idle == TIMEOUT) begin
          m_rdy = -1; m_drain = PD_LAT + 1;
        end
      end else begin
        m_drain--;
        if (m_drain == 0) begin m_ptr = m_lane; m_lane = -1; m_busy = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant", grant_o, oh(m_lane));
      chk("ready", req_ready_o, oh(m_rdy));
      chk("ready_onehot", ($countones(req_ready_o) <= 1), 1);
      chk("pd_clear", pd_clear_o, m_clear);
      chk("pd_valid", pd_valid_o, m_valid);
      if (m_valid) chk("pd_data", pd_data_o, m_data);
      chk("moore_ol", pd_moore_ol_o, m_ol);
      chk("moore_nol", pd_moore_nol_o, m_nol);
      chk("busy", busy_o, m_busy);
      chk("det_pulse", det_pulse_o, oh(m_pulse));
      chk("count0", det_count_o[3:0], m_cnt[0]);
      chk("count1", det_count_o[7:4], m_cnt[1]);
    end
  end

  // Scenario bookkeeping observed at the DUT ports
  int cyc = 0, tot_clear = 0, cur_acc = 0, last_acc_cyc = 0, busy_fall_cyc = 0;
  int tot_rdy [N], tot_acc [N], tot_pulse [N];
  int glog [$];
  int facc [$];
  logic ol_seen [N], nol_seen [N];
  logic [N-1:0] prev_grant = '0;
  logic prev_busy = 1'b0;

  initial for (int i = 0; i < N; i++) begin tot_rdy[i] = 0; tot_acc[i] = 0; tot_pulse[i] = 0; end

  always @(negedge clk) begin
    cyc++;
    tot_clear += int'(pd_clear_o);
    for (int i = 0; i < N; i++) begin
      tot_rdy[i] += int'(req_ready_o[i]);
      tot_pulse[i] += int'(det_pulse_o[i]);
      if (req_ready_o[i] && req_valid_i[i]) begin
        tot_acc[i]++; cur_acc++; last_acc_cyc = cyc;
      end
      if (req_ready_o[i]) begin ol_seen[i] = pd_moore_ol_o; nol_seen[i] = pd_moore_nol_o; end
    end
    if (prev_grant == '0 && grant_o != '0) glog.push_back(grant_o[1] ? 1 : 0);
    if (prev_grant != '0 && grant_o == '0) begin facc.push_back(cur_acc); cur_acc = 0; end
    if (prev_busy && !busy_o) busy_fall_cyc = cyc;
    prev_grant = grant_o;
    prev_busy = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40 && busy_o; i++) tick();
    chk(nm, busy_o, 0);
    repeat (2) tick();
  endtask

  int s_g, s_f, s_a, s_r, s_c, s_p;
  logic [7:0] pat = 8'b1011_0010;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {grant_o, req_ready_o, pd_clear_o, pd_valid_o, pd_data_o,
        pd_moore_ol_o, pd_moore_nol_o, det_pulse_o, det_count_o, busy_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fairness and mode programming (lane0 overlapping, lane1 non-overlapping)
    s_g = glog.size(); s_f = facc.size();
    req_valid_i = 2'b11;
    for (int i = 0; i < 200 && facc.size() - s_f < 4; i++) begin
      req_data_i = 2'(i ^ (i >> 2));
      tick();
    end
    req_valid_i = 2'b00;
    wait_idle("fair_done");
    for (int k = 0; k < 4; k++) begin
      chk("fair_grant_seq", glog[s_g + k], k % 2);
      chk("fair_frame_len", facc[s_f + k], 8);
    end
    chk("mode_l0_ol", ol_seen[0], 1);
    chk("mode_l0_nol", nol_seen[0], 0);
    chk("mode_l1_ol", ol_seen[1], 0);
    chk("mode_l1_nol", nol_seen[1], 1);

    // Single lane streaming; mode flipped mid-frame must not take effect yet
    s_c = tot_clear; s_r = tot_rdy[0]; s_a = tot_acc[0]; s_f = facc.size();
    req_valid_i = 2'b01;
    for (int i = 0; i < 40 && tot_acc[0] - s_a < 8; i++) begin
      req_data_i[0] = pat[i % 8];
      if (tot_acc[0] - s_a >= 3) lane_ol_i = 2'b10;
      tick();
    end
    req_valid_i = 2'b00;
    wait_idle("single_done");
    chk("single_clear_pulses", tot_clear - s_c, 1);
    chk("single_ready_cycles", tot_rdy[0] - s_r, 8);
    chk("single_accepts", tot_acc[0] - s_a, 8);
    chk("single_busy_drop", busy_fall_cyc - last_acc_cyc, 4);
    chk("single_mode_held", ol_seen[0], 1);

    // Timeout: lane0 sends 3 symbols then goes quiet, lane1 waits
    s_g = glog.size(); s_f = facc.size(); s_a = tot_acc[0]; s_r = tot_rdy[0];
    req_valid_i = 2'b01;
    for (int i = 0; i < 40 && tot_acc[0] - s_a < 3; i++) tick();
    req_valid_i = 2'b10;
    for (int i = 0; i < 80 && facc.size() - s_f < 2; i++) tick();
    req_valid_i = 2'b00;
    wait_idle("timeout_done");
    chk("timeout_accepts", facc[s_f], 3);
    chk("timeout_ready_cycles", tot_rdy[0] - s_r, 7);
    chk("timeout_first_lane", glog[s_g], 0);
    chk("timeout_next_lane", glog[s_g + 1], 1);
    chk("timeout_new_mode_l0", ol_seen[0], 0);
    chk("timeout_new_mode_l1", ol_seen[1], 1);

    // Hit in DRAIN, two cycles after lane0's last accept
    s_a = tot_acc[0]; s_p = tot_pulse[0];
    req_valid_i = 2'b01;
    for (int i = 0; i < 40 && tot_acc[0] - s_a < 8; i++) tick();
    req_valid_i = 2'b00;
    tick();
    pd_detected_i = 1'b1;
    wait_idle("attr_done");
    chk("attr_pulse0", tot_pulse[0] - s_p, 1);
    chk("attr_count0", det_count_o[3:0], 1);
    pd_detected_i = 1'b0;
    tick();
    pd_detected_i = 1'b1;
    repeat (2) tick();
    chk("idle_edge_ignored", det_count_o[3:0], 1);
    pd_detected_i = 1'b0;

    // Many hits on lane0 saturate its counter
    s_p = tot_pulse[0];
    req_valid_i = 2'b01;
    for (int i = 0; i < 120; i++) begin
      pd_detected_i = i[0];
      tick();
    end
    chk("sat_count0", det_count_o[3:0], 15);
    chk("sat_count1", det_count_o[7:4], 0);
    chk("sat_enough_hits", (tot_pulse[0] - s_p >= 20), 1);

    // Clear coincident with a hit
    for (int i = 0; i < 30 && !req_ready_o[0]; i++) tick();
    chk("clr_in_run", req_ready_o[0], 1);
    pd_detected_i = 1'b0;
    tick();
    pd_detected_i = 1'b1;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    @(negedge clk);
    chk("clr_wins_count0", det_count_o[3:0], 0);
    chk("clr_hit_pulse0", det_pulse_o[0], 1);
    req_valid_i = 2'b00;
    wait_idle("clr_done");
    chk("clr_count0_after", det_count_o[3:0], 0);

    // Reset mid-frame on lane1
    req_valid_i = 2'b10;
    for (int i = 0; i < 30 && !req_ready_o[1]; i++) tick();
    chk("rst_lane1_running", req_ready_o[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {grant_o, req_ready_o, pd_clear_o, pd_valid_o, pd_data_o,
        pd_moore_ol_o, pd_moore_nol_o, det_pulse_o, det_count_o, busy_o}, 0);
    req_valid_i = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && grant_o == '0; i++) tick();
    chk("rst_first_grant", grant_o, 2'b01);
    req_valid_i = 2'b00;
    wait_idle("rst_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
